// File: rtl/y86_instr_encoder_if.sv
// Instruction-load bus for the Y86-64 encoder.
// master: the program loader. It drives the decoded instruction fields, the
//         valid strobe and the write-pointer load.
// slave : the encoder. It returns in_ready, the byte-wide memory write port,
//         the write pointer and the status pulses.
// Signals: in_valid/in_ready handshake; icode/ifun/rA/rB/valC instruction
//          fields; addr_load/addr_in pointer load; mem_we/mem_addr/mem_wdata
//          memory write; wr_ptr next start address; done/err_invalid/mem_error
//          status pulses.
interface y86_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic        addr_load;
  logic [63:0] addr_in;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [63:0] wr_ptr;
  logic        done;
  logic        err_invalid;
  logic        mem_error;

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in,
    input  in_ready, mem_we, mem_addr, mem_wdata, wr_ptr, done,
           err_invalid, mem_error
  );

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in,
    output in_ready, mem_we, mem_addr, mem_wdata, wr_ptr, done,
           err_invalid, mem_error
  );
endinterface

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder. It takes one instruction as decoded fields and
// writes its byte image, little-endian, one byte per cycle into byte-wide
// instruction memory. Consecutive instructions pack contiguously from wr_ptr.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  y86_instr_encoder_if.slave: handshake, fields, pointer load,
//        memory write port, wr_ptr and the done/err_invalid/mem_error pulses
module y86_instr_encoder #(
  parameter int unsigned MEM_SIZE = 120
) (
  input logic             clk,
  input logic             rst,
  y86_instr_encoder_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_next;

  logic [63:0] wr_ptr_q;
  logic [3:0]  idx_q;
  logic [3:0]  len_q;
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [63:0] valc_q;
  logic [63:0] addr_hold;
  logic [7:0]  data_hold;
  logic        err_invalid_q;
  logic        mem_error_q;

  logic        in_ready;
  logic        accept;
  logic        icode_bad;
  logic        no_room;
  logic        last_byte;
  logic [3:0]  in_len;
  logic [63:0] emit_addr;
  logic [7:0]  emit_byte;
  logic [2:0]  valc_sel;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd0;
    endcase
  endfunction

  // Request decode. The room check is 65 bits wide so that a pointer near
  // 2^64 cannot wrap into a false fit.
  always_comb begin
    in_len    = instr_len(bus.icode);
    icode_bad = bus.icode > 4'hB;
    no_room   = ({1'b0, wr_ptr_q} + {61'd0, in_len}) > 65'(MEM_SIZE);
    in_ready  = (state == IDLE) && !bus.addr_load;
    accept    = bus.in_valid && in_ready;
    last_byte = idx_q == (len_q - 4'd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !icode_bad && !no_room) state_next = EMIT;
      EMIT:    if (last_byte) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. The address and data come straight from the pointer and index
  // while in EMIT. The hold registers keep the last written pair visible
  // while mem_we is low.
  always_comb begin
    valc_sel  = (len_q == 4'd9) ? 3'(idx_q - 4'd1) : 3'(idx_q - 4'd2);
    emit_addr = wr_ptr_q + {60'd0, idx_q};
    if (idx_q == 4'd0)
      emit_byte = {icode_q, ifun_q};
    else if (len_q != 4'd9 && idx_q == 4'd1)
      emit_byte = {ra_q, rb_q};
    else
      emit_byte = valc_q[{valc_sel, 3'b000} +: 8];

    bus.in_ready    = in_ready;
    bus.mem_we      = state == EMIT;
    bus.mem_addr    = (state == EMIT) ? emit_addr : addr_hold;
    bus.mem_wdata   = (state == EMIT) ? emit_byte : data_hold;
    bus.done        = (state == EMIT) && last_byte;
    bus.wr_ptr      = wr_ptr_q;
    bus.err_invalid = err_invalid_q;
    bus.mem_error   = mem_error_q;
  end

  // Datapath: pointer, latched fields, byte index and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      icode_q       <= '0;
      ifun_q        <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      valc_q        <= '0;
      addr_hold     <= '0;
      data_hold     <= '0;
      err_invalid_q <= 1'b0;
      mem_error_q   <= 1'b0;
    end else begin
      err_invalid_q <= 1'b0;
      mem_error_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.addr_load) begin
            wr_ptr_q <= bus.addr_in;
          end else if (accept) begin
            if (icode_bad) begin
              err_invalid_q <= 1'b1;
            end else if (no_room) begin
              mem_error_q <= 1'b1;
            end else begin
              icode_q <= bus.icode;
              ifun_q  <= bus.ifun;
              ra_q    <= (bus.icode == 4'h3) ? 4'hF : bus.rA;
              rb_q    <= (bus.icode == 4'hA || bus.icode == 4'hB) ? 4'hF : bus.rB;
              valc_q  <= bus.valC;
              len_q   <= in_len;
              idx_q   <= '0;
            end
          end
        end
        EMIT: begin
          addr_hold <= emit_addr;
          data_hold <= emit_byte;
          idx_q     <= idx_q + 4'd1;
          if (last_byte) wr_ptr_q <= wr_ptr_q + {60'd0, len_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
module tb_y86_instr_encoder;

  localparam int K_WRITE = 0;
  localparam int K_INV   = 1;
  localparam int K_MERR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  y86_instr_encoder_if bus ();

  y86_instr_encoder #(.MEM_SIZE(120)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Bench-side instruction memory
  logic [7:0] mem [0:119];
  always @(posedge clk)
    if (bus.mem_we && bus.mem_addr < 64'd120) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Log of one transaction, cycle 1 = first cycle after the accept edge
  int          nw, ndone, done_at, ninv, inv_at, nmerr, merr_at;
  logic [63:0] wa [0:11];
  logic [7:0]  wd [0:11];
  logic        rdy_hist  [0:12];
  logic [63:0] addr_hist [0:12];
  logic [7:0]  data_hist [0:12];

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, output bit ok);
    int w;
    ok = 1'b0;
    w  = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready still %b, required 1", bus.in_ready);
      return;
    end
    bus.icode = ic; bus.ifun = fn; bus.rA = ra; bus.rB = rb; bus.valC = vc;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Fields change after the accept; the encoder must ignore them
    bus.icode = ic ^ 4'h5; bus.ifun = ~fn; bus.rA = ~ra; bus.rB = ~rb; bus.valC = ~vc;
    nw = 0; ndone = 0; done_at = 0; ninv = 0; inv_at = 0; nmerr = 0; merr_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rdy_hist[c]  = bus.in_ready;
      addr_hist[c] = bus.mem_addr;
      data_hist[c] = bus.mem_wdata;
      if (bus.mem_we) begin
        if (nw < 12) begin
          wa[nw] = bus.mem_addr;
          wd[nw] = bus.mem_wdata;
        end
        nw++;
      end
      if (bus.done)        begin ndone++; done_at = c; end
      if (bus.err_invalid) begin ninv++;  inv_at  = c; end
      if (bus.mem_error)   begin nmerr++; merr_at = c; end
    end
    ok = 1'b1;
  endtask

  typedef struct {
    logic        load;
    logic [63:0] load_addr;
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc;
    int          kind;
    int          len;
    logic [79:0] img;    // byte 0 in bits 79:72
    logic [63:0] start;  // wr_ptr expected before the instruction
  } vec_t;

  typedef struct {
    logic [3:0]  ic, fn, ra, rb;
    logic [63:0] vc;
    int          len;
    logic [3:0]  era, erb;
  } prog_t;

  vec_t  vecs [0:15];
  prog_t prog [0:13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [79:0] img;
    logic [7:0]  eb;
    int          pc, nd;
    logic [7:0]  b0, b1;
    logic [3:0]  f_ic, f_fn, f_ra, f_rb;
    logic [63:0] f_vc;
    int          off, valp;
    bit          regids, hasc;

    vecs[0]  = '{1'b0, 64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, K_WRITE, 1, 80'h10_00_00_00_00_00_00_00_00_00, 64'd0};
    vecs[1]  = '{1'b0, 64'd0, 4'h3, 4'h0, 4'h0, 4'h2, 64'd255, K_WRITE, 10, 80'h30_F2_FF_00_00_00_00_00_00_00, 64'd1};
    vecs[2]  = '{1'b0, 64'd0, 4'h7, 4'h3, 4'h0, 4'h0, 64'd52, K_WRITE, 9, 80'h73_34_00_00_00_00_00_00_00_00, 64'd11};
    vecs[3]  = '{1'b0, 64'd0, 4'hC, 4'h0, 4'h1, 4'h2, 64'd7, K_INV, 0, 80'h0, 64'd20};
    vecs[4]  = '{1'b1, 64'd115, 4'h3, 4'h0, 4'h1, 4'h2, 64'd5, K_MERR, 0, 80'h0, 64'd115};
    vecs[5]  = '{1'b0, 64'd0, 4'h2, 4'h0, 4'h4, 4'h5, 64'd0, K_WRITE, 2, 80'h20_45_00_00_00_00_00_00_00_00, 64'd115};
    vecs[6]  = '{1'b0, 64'd0, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, K_WRITE, 1, 80'h90_00_00_00_00_00_00_00_00_00, 64'd117};
    vecs[7]  = '{1'b0, 64'd0, 4'hA, 4'h0, 4'h3, 4'h7, 64'd0, K_WRITE, 2, 80'hA0_3F_00_00_00_00_00_00_00_00, 64'd118};
    vecs[8]  = '{1'b0, 64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, K_MERR, 0, 80'h0, 64'd120};
    vecs[9]  = '{1'b1, 64'd0, 4'h4, 4'h0, 4'h1, 4'h2, 64'h8, K_WRITE, 10, 80'h40_12_08_00_00_00_00_00_00_00, 64'd0};
    vecs[10] = '{1'b0, 64'd0, 4'h8, 4'h0, 4'h1, 4'h2, 64'h100, K_WRITE, 9, 80'h80_00_01_00_00_00_00_00_00_00, 64'd10};
    vecs[11] = '{1'b0, 64'd0, 4'hB, 4'h0, 4'h4, 4'h3, 64'd0, K_WRITE, 2, 80'hB0_4F_00_00_00_00_00_00_00_00, 64'd19};
    vecs[12] = '{1'b0, 64'd0, 4'h5, 4'h0, 4'h6, 4'h7, 64'hFEDC_BA98_7654_3210, K_WRITE, 10, 80'h50_67_10_32_54_76_98_BA_DC_FE, 64'd21};
    vecs[13] = '{1'b0, 64'd0, 4'hF, 4'h1, 4'h1, 4'h1, 64'd0, K_INV, 0, 80'h0, 64'd31};
    vecs[14] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4'h3, 4'h0, 4'h1, 4'h2, 64'd9, K_MERR, 0, 80'h0, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[15] = '{1'b1, 64'd119, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, K_WRITE, 1, 80'h00_00_00_00_00_00_00_00_00_00, 64'd119};

    prog[0]  = '{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1, 4'hF, 4'hF};
    prog[1]  = '{4'h3, 4'h0, 4'h0, 4'h2, 64'h0123_4567_89AB_CDEF, 10, 4'hF, 4'h2};
    prog[2]  = '{4'h3, 4'h0, 4'h5, 4'h3, 64'h10, 10, 4'hF, 4'h3};
    prog[3]  = '{4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 2, 4'h2, 4'h3};
    prog[4]  = '{4'h6, 4'h1, 4'h3, 4'h2, 64'd0, 2, 4'h3, 4'h2};
    prog[5]  = '{4'h2, 4'h0, 4'h4, 4'h5, 64'd0, 2, 4'h4, 4'h5};
    prog[6]  = '{4'h2, 4'h5, 4'h1, 4'h6, 64'd0, 2, 4'h1, 4'h6};
    prog[7]  = '{4'h7, 4'h4, 4'hF, 4'hF, 64'h1C, 9, 4'hF, 4'hF};
    prog[8]  = '{4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 9, 4'hF, 4'hF};
    prog[9]  = '{4'h6, 4'h3, 4'hA, 4'hB, 64'd0, 2, 4'hA, 4'hB};
    prog[10] = '{4'h6, 4'h2, 4'h7, 4'h8, 64'd0, 2, 4'h7, 4'h8};
    prog[11] = '{4'h2, 4'h0, 4'hE, 4'h1, 64'd0, 2, 4'hE, 4'h1};
    prog[12] = '{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 1, 4'hF, 4'hF};
    prog[13] = '{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 1, 4'hF, 4'hF};

    bus.in_valid = 1'b0; bus.addr_load = 1'b0; bus.addr_in = '0;
    bus.icode = '0; bus.ifun = '0; bus.rA = '0; bus.rB = '0; bus.valC = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err_invalid", 64'(bus.err_invalid), 64'd0);
    chk("rst_mem_error", 64'(bus.mem_error), 64'd0);
    chk("rst_wr_ptr", bus.wr_ptr, 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].load) begin
        @(negedge clk);
        bus.addr_load = 1'b1; bus.addr_in = vecs[i].load_addr;
        bus.in_valid = 1'b1; bus.icode = 4'h1; bus.ifun = 4'h0;
        #1 chk("ready_during_load", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 bus.addr_load = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("load_no_write", 64'(bus.mem_we), 64'd0);
        chk("load_wr_ptr", bus.wr_ptr, vecs[i].load_addr);
      end
      chk("start_ptr", bus.wr_ptr, vecs[i].start);
      send(vecs[i].ic, vecs[i].fn, vecs[i].ra, vecs[i].rb, vecs[i].vc, ok);
      if (!ok) continue;
      if (vecs[i].kind == K_WRITE) begin
        img = vecs[i].img;
        chk("nwrites", 64'(nw), 64'(vecs[i].len));
        for (int k = 0; k < vecs[i].len && k < nw && k < 12; k++) begin
          eb = img[79 - 8*k -: 8];
          chk("wr_addr", wa[k], vecs[i].start + 64'(k));
          chk("wr_data", 64'(wd[k]), 64'(eb));
        end
        eb = img[79 - 8*(vecs[i].len - 1) -: 8];
        chk("done_count", 64'(ndone), 64'd1);
        chk("done_cycle", 64'(done_at), 64'(vecs[i].len));
        chk("busy_ready", 64'(rdy_hist[1]), 64'd0);
        chk("ready_again", 64'(rdy_hist[vecs[i].len + 1]), 64'd1);
        chk("hold_addr", addr_hist[vecs[i].len + 1], vecs[i].start + 64'(vecs[i].len - 1));
        chk("hold_data", 64'(data_hist[vecs[i].len + 1]), 64'(eb));
        chk("no_err_pulses", 64'(ninv + nmerr), 64'd0);
        chk("end_wr_ptr", bus.wr_ptr, vecs[i].start + 64'(vecs[i].len));
      end else begin
        chk("err_nwrites", 64'(nw), 64'd0);
        chk("err_ready", 64'(rdy_hist[1]), 64'd1);
        chk("err_done", 64'(ndone), 64'd0);
        chk("err_wr_ptr", bus.wr_ptr, vecs[i].start);
        if (vecs[i].kind == K_INV) begin
          chk("inv_count", 64'(ninv), 64'd1);
          chk("inv_cycle", 64'(inv_at), 64'd1);
          chk("inv_no_merr", 64'(nmerr), 64'd0);
        end else begin
          chk("merr_count", 64'(nmerr), 64'd1);
          chk("merr_cycle", 64'(merr_at), 64'd1);
          chk("merr_no_inv", 64'(ninv), 64'd0);
        end
      end
    end

    // Reset during the 4th byte of an irmovq
    @(negedge clk);
    bus.addr_load = 1'b1; bus.addr_in = 64'd60;
    @(posedge clk);
    #1 bus.addr_load = 1'b0;
    @(negedge clk);
    bus.icode = 4'h3; bus.ifun = 4'h0; bus.rA = 4'h1; bus.rB = 4'h2;
    bus.valC = 64'h1122_3344_5566_7788; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    nd = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (c == 4) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    if (bus.done) nd++;
    chk("midrst_no_done", 64'(nd), 64'd0);
    chk("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("midrst_wr_ptr", bus.wr_ptr, 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_mem_addr", bus.mem_addr, 64'd0);
    chk("midrst_kept_b0", 64'(mem[60]), 64'h30);
    chk("midrst_kept_b3", 64'(mem[63]), 64'h77);

    // Round trip: 55-byte program from address 0, then fetch-decode it back
    chk("rt_start_ptr", bus.wr_ptr, 64'd0);
    for (int i = 0; i < 14; i++) begin
      send(prog[i].ic, prog[i].fn, prog[i].ra, prog[i].rb, prog[i].vc, ok);
      if (ok) chk("rt_done", 64'(ndone), 64'd1);
    end
    chk("rt_end_ptr", bus.wr_ptr, 64'd55);
    pc = 0;
    for (int i = 0; i < 14; i++) begin
      b0 = mem[pc];
      f_ic = b0[7:4];
      f_fn = b0[3:0];
      regids = f_ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      hasc   = f_ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
      f_ra = 4'hF;
      f_rb = 4'hF;
      if (regids) begin
        b1 = mem[pc + 1];
        f_ra = b1[7:4];
        f_rb = b1[3:0];
      end
      off  = pc + 1 + (regids ? 1 : 0);
      f_vc = '0;
      if (hasc)
        for (int j = 0; j < 8; j++) f_vc[8*j +: 8] = mem[off + j];
      valp = off + (hasc ? 8 : 0);
      chk("rt_icode", 64'(f_ic), 64'(prog[i].ic));
      chk("rt_ifun", 64'(f_fn), 64'(prog[i].fn));
      chk("rt_rA", 64'(f_ra), 64'(prog[i].era));
      chk("rt_rB", 64'(f_rb), 64'(prog[i].erb));
      chk("rt_valC", f_vc, prog[i].vc);
      chk("rt_valP", 64'(valp), 64'(pc + prog[i].len));
      pc = pc + prog[i].len;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
